// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, free-running oversample tick, mid-bit sampling FSM.
// Byte strobed ~N_TICKS/2+N_TICKS*(NB_DATA+1) ticks after start edge; no backpressure, every strobe must be consumed.
module uart_rx #(
  parameter int NB_DATA   = 8,
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 19200,
  parameter int N_TICKS   = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done,
  output logic               o_frame_error,
  output logic               o_busy
);

  localparam int DIV_CALC = (CLK_FREQ + BAUD_RATE * N_TICKS / 2) / (BAUD_RATE * N_TICKS);
  localparam int DIV      = (DIV_CALC < 1) ? 1 : DIV_CALC;
  localparam int TW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW       = $clog2(N_TICKS);
  localparam int NW       = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] S_MID     = SW'(N_TICKS / 2 - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(N_TICKS - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(NB_DATA - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } state_t;

  logic [TW-1:0]      r_tick_cnt;
  logic               w_tick;
  logic [1:0]         r_sync;
  logic               w_rx_s;

  state_t             r_state, w_state_nxt;
  logic [SW-1:0]      r_s, w_s_nxt;
  logic [NW-1:0]      r_n, w_n_nxt;
  logic [NB_DATA-1:0] r_shift, w_shift_nxt;
  logic [NB_DATA:0]   w_shift_cat;
  logic [NB_DATA-1:0] r_rx_data, w_rx_data_nxt;
  logic               r_rx_done, w_rx_done_nxt;
  logic               r_frame_error, w_frame_error_nxt;

  // Tick never rephases on the start edge; the FSM tolerates up to DIV-1 clocks of skew.
  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_rx};
    end
  end

  assign w_rx_s      = r_sync[1];
  assign w_shift_cat = {w_rx_s, r_shift};

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_s           <= '0;
      r_n           <= '0;
      r_shift       <= '0;
      r_rx_data     <= '0;
      r_rx_done     <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_s           <= w_s_nxt;
      r_n           <= w_n_nxt;
      r_shift       <= w_shift_nxt;
      r_rx_data     <= w_rx_data_nxt;
      r_rx_done     <= w_rx_done_nxt;
      r_frame_error <= w_frame_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_s_nxt           = r_s;
    w_n_nxt           = r_n;
    w_shift_nxt       = r_shift;
    w_rx_data_nxt     = r_rx_data;
    w_rx_done_nxt     = 1'b0;
    w_frame_error_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = ST_START;
          w_s_nxt     = '0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_s == S_MID) begin
            if (!w_rx_s) begin
              w_state_nxt = ST_DATA;
              w_s_nxt     = '0;
              w_n_nxt     = '0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_s == S_LAST) begin
            w_shift_nxt = w_shift_cat[NB_DATA:1];
            w_s_nxt     = '0;
            if (r_n == N_LAST) begin
              w_state_nxt = ST_STOP;
            end else begin
              w_n_nxt = r_n + 1'b1;
            end
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_s == S_LAST) begin
            w_s_nxt = '0;
            // Returning to IDLE at mid-stop lets a back-to-back start bit be caught.
            if (w_rx_s) begin
              w_rx_data_nxt = r_shift;
              w_rx_done_nxt = 1'b1;
              w_state_nxt   = ST_IDLE;
            end else begin
              w_frame_error_nxt = 1'b1;
              w_state_nxt       = ST_WAIT_IDLE;
            end
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (w_rx_s) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_rx_data     = r_rx_data;
  assign o_rx_done     = r_rx_done;
  assign o_frame_error = r_frame_error;
  assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for the debug link; sits directly upstream of debug_unit.
- Oversamples the serial line, deframes 8N1 characters and presents each byte on o_rx_data with a one-cycle o_rx_done strobe.
- o_rx_data and o_rx_done connect to debug_unit i_rx_data / i_rx_done; clocked by the clk_wiz output (50 MHz).

Parameters:
- NB_DATA, 8, data bits per frame.
- CLK_FREQ, 50000000, input clock frequency in Hz.
- BAUD_RATE, 19200, line rate in bit/s.
- N_TICKS, 16, oversampling ticks per bit; must be even and >= 4.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx  in  1  serial line; idles high; asynchronous to i_clock.
- o_rx_data  out  NB_DATA  last correctly framed byte.
- o_rx_done  out  1  one-cycle pulse when o_rx_data updates.
- o_frame_error  out  1  one-cycle pulse when the stop bit is sampled low.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (i_reset=0, takes effect immediately, no clock needed):
  - state IDLE; all counters 0.
  - both synchronizer flops 1.
  - o_rx_data=0, o_rx_done=0, o_frame_error=0, o_busy=0.
- Synchronizer: i_rx passes through 2 flops to rx_s; all logic uses rx_s only.
- Tick generator:
  - DIV = (CLK_FREQ + BAUD_RATE*N_TICKS/2) / (BAUD_RATE*N_TICKS), rounded; DIV >= 1.
  - Counter runs 0..DIV-1 continuously and pulses tick for one clock at DIV-1.
  - Never stalled or rephased; start-edge phase error <= DIV-1 clocks.
- Counters: s (sample, width clog2(N_TICKS)); n (bit, width clog2(NB_DATA)).
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when rx_s==0, go to START with s=0.
  - START: on each tick, if s==N_TICKS/2-1, check rx_s:
    - rx_s==0: go to DATA with s=0, n=0.
    - rx_s==1: glitch; go to IDLE with no outputs.
    - Otherwise s++.
  - DATA: on each tick, if s==N_TICKS-1:
    - shift rx_s into the MSB of shift register (shift right, LSB-first line order); s=0.
    - if n==NB_DATA-1, go to STOP; else n++.
    - Otherwise s++.
  - STOP: on each tick, if s==N_TICKS-1, check rx_s:
    - rx_s==1: load o_rx_data from shift register, pulse o_rx_done, go to IDLE.
    - rx_s==0: pulse o_frame_error, leave o_rx_data unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then go to IDLE. A held-low line (break) never produces spurious frames.
- Outputs:
  - o_rx_done and o_frame_error are registered, high exactly one clock, and never high together.
  - o_rx_data holds its value between frames.
- Latency: mid-stop sample occurs N_TICKS/2 + N_TICKS*(NB_DATA+1) ticks after START entry (152 ticks at defaults), plus 2 synchronizer clocks and <= DIV-1 clocks of tick phase.
- Back-to-back frames: IDLE is re-entered at mid-stop, so a start bit immediately following the stop bit is detected.
- Reset mid-frame: the partial byte is discarded; the next full frame after release is received normally.
- No overrun detection; debug_unit consumes every strobe.

Test Plan:
Bench parameters: CLK_FREQ=3200000, BAUD_RATE=100000, N_TICKS=16, giving DIV=2 and 32 clocks per bit.
1. Hold i_reset=0 with i_rx=1 -> o_rx_data=0x00; o_rx_done, o_frame_error and o_busy all 0; state held while reset is low.
2. Send 8N1 frame 0xA5 -> exactly one o_rx_done pulse within 308 clocks of the falling edge; o_rx_data=0xA5; o_frame_error stays 0.
3. Drive i_rx low for 6 clocks, then high -> o_busy rises then returns to 0; no o_rx_done or o_frame_error; o_rx_data stays 0xA5.
4. Send 0x3C with stop bit 0, then hold i_rx low for 200 clocks:
   - one o_frame_error pulse; o_rx_data stays 0xA5; o_busy stays 1.
   - release i_rx high, then send 0x5A -> o_rx_done with o_rx_data=0x5A.
5. Send 0x00 immediately followed by 0xFF (zero idle gap) -> two o_rx_done pulses, data 0x00 then 0xFF, no frame error.
6. Assert i_reset=0 during data bit 4 of 0x77 -> outputs cleared at once and no strobe fires; after release, send 0x81 -> o_rx_data=0x81.
